// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the program loader.
// ST_CHECK exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

   localparam int unsigned LOADER_ADDR_W      = 9;
   localparam int unsigned LOADER_DEPTH       = 512;
   localparam int unsigned LOADER_HOLD_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK = 3'd1,
`endif
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

endpackage

// File: rtl/loader_checksum.sv
// Running mod-256 sum of the image bytes written to memory.
// Instantiated by program_loader only when LOADER_CHECKSUM_EN is defined.
module loader_checksum (
   input  logic       clk,
   input  logic       reset,
   input  logic       add_i,
   input  logic [7:0] data_i,
   output logic [7:0] sum_o
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (add_i) begin
         sum_d = sum_q + data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Streams an image into instruction ROM / data RAM, then releases the core from reset.
// Optional trailing checksum byte is enabled with the LOADER_CHECKSUM_EN macro.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = LOADER_ADDR_W,
   parameter int unsigned DEPTH       = LOADER_DEPTH,
   parameter int unsigned HOLD_CYCLES = LOADER_HOLD_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              rom_we,
   output logic              ram_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   byte_count
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                ready_q, ready_d;
   logic                core_reset_q, done_q, error_q;
   logic                accept_c;

   assign accept_c = in_valid && ready_q;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_c;

   loader_checksum u_checksum (
      .clk    (clk),
      .reset  (reset),
      .add_i  (we_d),
      .data_i (in_data),
      .sum_o  (sum_c)
   );
`endif

   // Next-state, counters and write strobe
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hold_d  = hold_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_LOAD: begin
            if (accept_c) begin
               if (count_q == CNT_W'(DEPTH)) begin
                  state_d = ST_ERROR;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = count_q[ADDR_W-1:0];
                  wdata_d = in_data;
                  count_d = count_q + CNT_W'(1);
                  if (in_last) begin
`ifdef LOADER_CHECKSUM_EN
                     state_d = ST_CHECK;
`else
                     state_d = ST_HOLD;
`endif
                  end
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept_c) begin
               state_d = (in_data == sum_c) ? ST_HOLD : ST_ERROR;
            end
         end
`endif
         ST_HOLD: begin
            if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
               state_d = ST_RUN;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   assign ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
   assign ready_d = (state_d == ST_LOAD);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_LOAD;
         count_q      <= '0;
         hold_q       <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 8'h00;
         ready_q      <= 1'b0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         hold_q       <= hold_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ready_q      <= ready_d;
         core_reset_q <= (state_d != ST_RUN);
         done_q       <= (state_d == ST_RUN);
         error_q      <= (state_d == ST_ERROR);
      end
   end

   assign in_ready   = ready_q;
   assign rom_we     = we_q;
   assign ram_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign core_reset = core_reset_q;
   assign done       = done_q;
   assign error      = error_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with ROM/RAM models and a strobe address log.
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
`define TB_FIN(s) send(s, 1'b0)
`else
`define TB_FIN(s)
`endif

module tb_program_loader;

   localparam int unsigned AW    = 9;
   localparam int unsigned DEPTH = 512;
   localparam int unsigned LOGN  = 4096;
`ifdef LOADER_CHECKSUM_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_last = 1'b0;
   logic          in_ready, rom_we, ram_we, core_reset, done, error;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [AW:0]   byte_count;

   int checks = 0;
   int failures = 0;

   logic [7:0]    rom_m [DEPTH];
   logic [7:0]    ram_m [DEPTH];
   int unsigned   we_cnt = 0;
   logic [AW-1:0] st_addr [LOGN];

   always #5 clk = ~clk;

   program_loader dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .rom_we     (rom_we),
      .ram_we     (ram_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_reset (core_reset),
      .done       (done),
      .error      (error),
      .byte_count (byte_count)
   );

   // Memory models and strobe log
   always @(posedge clk) begin
      if (rom_we) begin
         rom_m[mem_addr] = mem_wdata;
         if (we_cnt < LOGN) st_addr[we_cnt] = mem_addr;
         we_cnt = we_cnt + 1;
      end
      if (ram_we) ram_m[mem_addr] = mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic expect_release(input string tag);
      chk({tag, "_cr0"}, 32'(core_reset), 32'd1);
      chk({tag, "_dn0"}, 32'(done), 32'd0);
      tick();
      chk({tag, "_cr1"}, 32'(core_reset), 32'd1);
      chk({tag, "_dn1"}, 32'(done), 32'd0);
      tick();
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_cr2"}, 32'(core_reset), 32'd0);
      chk({tag, "_err"}, 32'(error), 32'd0);
   endtask

   initial begin
      int unsigned base;
      logic [7:0]  sum;
      logic [7:0]  d;

      // Reset state
      tick();
      tick();
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'({rom_we, ram_we}), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_core", 32'(core_reset), 32'd1);
      chk("rst_flags", 32'({done, error}), 32'd0);
      chk("rst_count", 32'(byte_count), 32'd0);
      reset = 1'b0;
      tick();

      // Four back-to-back bytes
      base = we_cnt;
      send(8'h93, 1'b0);
      chk("a_we0", 32'({rom_we, ram_we}), 32'h3);
      chk("a_addr0", 32'(mem_addr), 32'd0);
      send(8'h00, 1'b0);
      send(8'h50, 1'b0);
      send(8'h00, 1'b1);
      chk("a_we3", 32'({rom_we, ram_we}), 32'h3);
      chk("a_addr3", 32'(mem_addr), 32'd3);
      chk("a_count", 32'(byte_count), 32'd4);
      chk("a_rdy_last", 32'(in_ready), 32'(CHK_EN));
      `TB_FIN(8'hE3);
      expect_release("a");
      chk("a_nstrobe", we_cnt - base, 32'd4);
      chk("a_rom", {rom_m[0], rom_m[1], rom_m[2], rom_m[3]}, 32'h93005000);
      chk("a_ram", {ram_m[0], ram_m[1], ram_m[2], ram_m[3]}, 32'h93005000);
      in_valid = 1'b1;
      in_data = 8'hFF;
      repeat (4) tick();
      in_valid = 1'b0;
      chk("a_run_ignore", we_cnt - base, 32'd4);
      chk("a_run_hold", 32'({done, in_ready, byte_count}), 32'({1'b1, 1'b0, 10'd4}));

      // in_valid toggling every cycle
      do_reset();
      base = we_cnt;
      for (int i = 0; i < 8; i++) begin
         send(8'h10 + 8'(i), (i == 7));
         if (i != 7) tick();
      end
      `TB_FIN(8'h9C);
      expect_release("b");
      chk("b_nstrobe", we_cnt - base, 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("b_addr", 32'(st_addr[base + i]), 32'(i));
         chk("b_data", 32'(rom_m[i]), 32'(8'h10 + 8'(i)));
      end

      // Full-depth image completes
      do_reset();
      sum = 8'h00;
      for (int i = 0; i < 512; i++) begin
         d = 8'(i) ^ 8'h5A;
         sum = sum + d;
         send(d, (i == 511));
      end
      chk("c_count", 32'(byte_count), 32'd512);
      chk("c_addr_top", 32'(mem_addr), 32'd511);
      `TB_FIN(sum);
      expect_release("c");

      // Overflow without in_last goes to error, no wrap
      do_reset();
      base = we_cnt;
      for (int i = 0; i < 512; i++) send(8'hEE, 1'b0);
      send(8'h77, 1'b0);
      chk("c_ovf_err", 32'(error), 32'd1);
      chk("c_ovf_we", 32'(rom_we), 32'd0);
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("c_ovf_nstrobe", we_cnt - base, 32'd512);
      chk("c_ovf_rom0", 32'(rom_m[0]), 32'hEE);
      chk("c_ovf_ram0", 32'(ram_m[0]), 32'hEE);
      chk("c_ovf_flags", 32'({error, core_reset, done, in_ready}), 32'b1100);
      chk("c_ovf_count", 32'(byte_count), 32'd512);

      // Reset mid-load restarts at address 0
      do_reset();
      send(8'h30, 1'b0);
      send(8'h31, 1'b0);
      send(8'h32, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk("d_rst_we", 32'(rom_we), 32'd0);
      chk("d_rst_cnt", 32'(byte_count), 32'd0);
      chk("d_rst_rdy", 32'(in_ready), 32'd0);
      reset = 1'b0;
      tick();
      base = we_cnt;
      for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), (i == 5));
      chk("d_first_addr", 32'(st_addr[base]), 32'd0);
      chk("d_count", 32'(byte_count), 32'd6);
      `TB_FIN(8'hCF);
      expect_release("d");
      for (int i = 0; i < 6; i++) chk("d_mem", 32'(rom_m[i]), 32'(8'hA0 + 8'(i)));

`ifdef LOADER_CHECKSUM_EN
      // Good checksum
      do_reset();
      base = we_cnt;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b1);
      send(8'h06, 1'b0);
      expect_release("e");
      chk("e_nstrobe", we_cnt - base, 32'd3);
      chk("e_count", 32'(byte_count), 32'd3);

      // Bad checksum
      do_reset();
      base = we_cnt;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b1);
      send(8'h07, 1'b0);
      repeat (3) tick();
      chk("e_bad_flags", 32'({error, done, core_reset}), 32'b101);
      chk("e_bad_nstrobe", we_cnt - base, 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: byte address width of instruction ROM and data RAM.
REQ-002 SHALL have parameter DEPTH, default 512: bytes per memory; maximum image size.
REQ-003 SHALL have parameter HOLD_CYCLES, default 2: cycles core_reset stays high after a good load.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data/in_last carry a byte this cycle.
REQ-007 in_data  input  8  image byte, little-endian byte order.
REQ-008 in_last  input  1  current byte is the final image byte.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 rom_we, ram_we  output  1 each  byte write strobes to ROM and RAM.
REQ-011 mem_addr  output  ADDR_W  shared write address for both memories.
REQ-012 mem_wdata  output  8  shared write data.
REQ-013 core_reset  output  1  reset to the PPU pipeline (PC, pipeline registers).
REQ-014 done  output  1  image loaded, core released.
REQ-015 error  output  1  load failed; core held in reset.
REQ-016 byte_count  output  ADDR_W+1  bytes written so far.

Function
REQ-017 A byte SHALL be accepted only on a cycle with in_valid && in_ready.
REQ-018 States SHALL be LOAD, CHECK, HOLD, RUN, ERROR; in_ready SHALL be 1 only in LOAD and CHECK.
REQ-019 Each byte accepted in LOAD SHALL be written the following cycle: rom_we=ram_we=1, mem_addr=byte_count before the increment, mem_wdata=the byte; 1-cycle latency, one strobe cycle per byte.
REQ-020 byte_count SHALL increment by 1 per byte accepted in LOAD and hold otherwise.
REQ-021 A byte accepted in LOAD with in_last=1 SHALL be written, and the FSM SHALL go to CHECK if LOADER_CHECKSUM_EN is defined, else HOLD.
REQ-022 A byte accepted in LOAD while byte_count==DEPTH SHALL NOT be written, and the FSM SHALL go to ERROR (no address wrap-around).
REQ-023 The byte at byte_count==DEPTH-1 with in_last=1 SHALL complete normally.
REQ-024 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to RUN.
REQ-025 core_reset SHALL be 1 in every state except RUN.
REQ-026 In RUN, done SHALL be 1 and the FSM SHALL hold until reset; in_valid SHALL be ignored.
REQ-027 In ERROR, error SHALL be 1 and the FSM SHALL hold until reset; no further writes SHALL occur.
REQ-028 rom_we and ram_we SHALL never assert except per REQ-019.

Reset
REQ-029 reset SHALL force: state=LOAD, byte_count=0, rom_we=ram_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0, in_ready=0 during the reset cycle.
REQ-030 Reset mid-load SHALL cancel any pending write strobe, restart at address 0, and leave memory contents untouched.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined, a running 8-bit sum (mod 256) of written bytes SHALL be kept; the one byte accepted in CHECK SHALL NOT be written and SHALL be compared to the sum: equal -> HOLD, unequal -> ERROR.
REQ-032 Without LOADER_CHECKSUM_EN, CHECK and the sum register SHALL NOT exist, and in_last SHALL go directly to HOLD.

Structure
REQ-033 State encoding and the default ADDR_W/DEPTH/HOLD_CYCLES constants SHALL live in the shared package loader_pkg.
REQ-034 The FSM and counters SHALL be in program_loader; the checksum accumulator SHALL be the single sub-module loader_checksum, instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-035 Macro off; 4 bytes 0x93,0x00,0x50,0x00 back-to-back, last on 4th -> ROM/RAM[0..3] hold those bytes; byte_count=4; core_reset high 2 cycles after the last write strobe, then done=1.
REQ-036 in_valid toggled 1/0 every cycle over 8 bytes -> exactly 8 write strobes at addresses 0..7; no duplicates or skips.
REQ-037 DEPTH=512; 512 bytes, last on 512th -> done=1. Separately, 513 bytes with no in_last -> error=1, address 0 not overwritten, core_reset stays 1.
REQ-038 reset asserted after 3 of 6 bytes, then 6 fresh bytes 0xA0..0xA5 -> first post-reset write at address 0; final memory[0..5]=0xA0..0xA5.
REQ-039 Macro on; bytes 0x01,0x02,0x03 (last) then checksum 0x06 -> done=1 and no write of 0x06. Checksum 0x07 instead -> error=1 and done=0.
